// File: rtl/cisr_row_len_sched_if.sv
// Port bundle for the CISR row-length scheduler.
// With CISR_SCHED_PERF_EN defined the bundle also carries perf_bubble_cycles.
interface cisr_row_len_sched_if #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 16
);
    logic                           start;
    logic [DIM_W-1:0]               num_rows;
    logic                           busy;
    logic                           done;
    logic                           len_valid;
    logic [DATA_W-1:0]              len_data;
    logic                           len_ready;
    logic                           ext_stall;
    logic                           spmv_init;
    logic [NUM_CH-1:0][DATA_W-1:0]  row_len;
    logic [NUM_CH-1:0]              row_len_pop;
    logic                           pipe_bubble;
`ifdef CISR_SCHED_PERF_EN
    logic [31:0]                    perf_bubble_cycles;

    modport slave (
        input  start, num_rows, len_valid, len_data, ext_stall, row_len_pop,
        output busy, done, len_ready, spmv_init, row_len, pipe_bubble, perf_bubble_cycles
    );
    modport master (
        output start, num_rows, len_valid, len_data, ext_stall, row_len_pop,
        input  busy, done, len_ready, spmv_init, row_len, pipe_bubble, perf_bubble_cycles
    );
`else
    modport slave (
        input  start, num_rows, len_valid, len_data, ext_stall, row_len_pop,
        output busy, done, len_ready, spmv_init, row_len, pipe_bubble
    );
    modport master (
        output start, num_rows, len_valid, len_data, ext_stall, row_len_pop,
        input  busy, done, len_ready, spmv_init, row_len, pipe_bubble
    );
`endif
endinterface

// File: rtl/cisr_row_len_sched.sv
// Row-length scheduler for the CISR SpMV decoder: stages one row length per channel.
// Optional macro CISR_SCHED_PERF_EN adds a saturating RUN-bubble cycle counter.
module cisr_row_len_sched #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cisr_row_len_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [NUM_CH-1:0] CH_ONE  = {{(NUM_CH-1){1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0]  DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

    function automatic logic [DIM_W-1:0] count_ones(input logic [NUM_CH-1:0] vec);
        logic [DIM_W-1:0] acc;
        acc = {DIM_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (vec[i]) begin
                acc = acc + DIM_ONE;
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_t                         state_r;
    state_t                         next_state_s;
    logic [NUM_CH-1:0][DATA_W-1:0]  slot_r;
    logic [NUM_CH-1:0]              full_r;
    logic [NUM_CH-1:0]              pad_r;
    logic [DIM_W-1:0]               fetched_r;
    logic [DIM_W-1:0]               consumed_r;
    logic [DIM_W-1:0]               rows_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           init_r;

    logic                           start_acc_s;
    logic [NUM_CH-1:0]              empty_s;
    logic                           any_empty_s;
    logic [NUM_CH-1:0]              tgt_oh_s;
    logic                           active_s;
    logic                           need_real_s;
    logic                           len_ready_s;
    logic                           fill_real_s;
    logic                           fill_pad_s;
    logic [NUM_CH-1:0]              fill_oh_s;
    logic                           bubble_s;
    logic [NUM_CH-1:0]              pop_s;
    logic [DIM_W-1:0]               consumed_nxt_s;
    logic [NUM_CH-1:0]              full_nxt_s;

    // Lowest empty slot is the refill target; real lengths until num_rows fetched, then pads
    always_comb begin
        start_acc_s = (state_r == ST_IDLE) && bus.start;
        empty_s     = ~full_r;
        any_empty_s = |empty_s;
        tgt_oh_s    = empty_s & (full_r + CH_ONE);
        active_s    = (state_r == ST_LOAD) || (state_r == ST_RUN);
        need_real_s = (fetched_r < rows_r);
        len_ready_s = active_s && any_empty_s && need_real_s;
        fill_real_s = len_ready_s && bus.len_valid;
        fill_pad_s  = active_s && any_empty_s && !need_real_s;
        if (fill_real_s || fill_pad_s) begin
            fill_oh_s = tgt_oh_s;
        end else begin
            fill_oh_s = {NUM_CH{1'b0}};
        end
    end

    // Pops are only honoured with every slot full, so a popped slot is never refilled in the same cycle
    always_comb begin
        bubble_s = (state_r != ST_RUN) || bus.ext_stall || any_empty_s;
        if (!bubble_s) begin
            pop_s = bus.row_len_pop;
        end else begin
            pop_s = {NUM_CH{1'b0}};
        end
        consumed_nxt_s = consumed_r + count_ones(pop_s & ~pad_r);
        full_nxt_s     = (full_r & ~pop_s) | fill_oh_s;
    end

    // Pass sequencing
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_rows == {DIM_W{1'b0}}) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (&full_nxt_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (consumed_nxt_s == rows_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Slot contents, flags and row counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r     <= {(NUM_CH*DATA_W){1'b0}};
            full_r     <= {NUM_CH{1'b0}};
            pad_r      <= {NUM_CH{1'b0}};
            fetched_r  <= {DIM_W{1'b0}};
            consumed_r <= {DIM_W{1'b0}};
            rows_r     <= {DIM_W{1'b0}};
        end else if (start_acc_s) begin
            slot_r     <= {(NUM_CH*DATA_W){1'b0}};
            full_r     <= {NUM_CH{1'b0}};
            pad_r      <= {NUM_CH{1'b0}};
            fetched_r  <= {DIM_W{1'b0}};
            consumed_r <= {DIM_W{1'b0}};
            rows_r     <= bus.num_rows;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fill_oh_s[i]) begin
                    slot_r[i] <= fill_real_s ? bus.len_data : {DATA_W{1'b0}};
                    pad_r[i]  <= fill_pad_s;
                end
            end
            // Leftover pad slots are dropped when the pass completes
            if ((state_r == ST_RUN) && (next_state_s == ST_DONE)) begin
                full_r <= {NUM_CH{1'b0}};
            end else begin
                full_r <= full_nxt_s;
            end
            if (fill_real_s) begin
                fetched_r <= fetched_r + DIM_ONE;
            end
            consumed_r <= consumed_nxt_s;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            init_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (next_state_s == ST_DONE);
            init_r <= start_acc_s && (bus.num_rows != {DIM_W{1'b0}});
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.spmv_init   = init_r;
    assign bus.len_ready   = len_ready_s;
    assign bus.row_len     = slot_r;
    assign bus.pipe_bubble = bubble_s;

`ifdef CISR_SCHED_PERF_EN
    logic [31:0] perf_r;

    // Saturating count of RUN cycles spent in a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 32'd0;
        end else if (start_acc_s) begin
            perf_r <= 32'd0;
        end else if ((state_r == ST_RUN) && bubble_s && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end
    end

    assign bus.perf_bubble_cycles = perf_r;
`endif

endmodule

// File: doc/cisr_row_len_sched.md
Name: cisr_row_len_sched

Overview:
- Row-length scheduler and sequencer for the CISR SpMV front end.
- Accepts the row-length stream from the memory fetch unit and keeps one staged row length per channel for the CISR decoder.
- Refills channels in the same ascending-channel priority order the decoder uses to assign row indices, and drives spmv_init and pipe_bubble.
- Runs one SpMV pass per start pulse and reports completion.

Parameters:
NUM_CH, 16, number of decoder channels
DATA_W, 32, row-length width
DIM_W, 16, row-count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin pass; ignored unless IDLE
num_rows  in  DIM_W  rows in matrix; sampled on accepted start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at pass completion
len_valid  in  1  row-length stream valid
len_data  in  DATA_W  row length
len_ready  out  1  row-length stream ready
ext_stall  in  1  downstream stall (value/col stream not ready)
spmv_init  out  1  decoder restart pulse
row_len  out  NUM_CH x DATA_W  staged row length per channel
row_len_pop  in  NUM_CH  decoder consumes channel i
pipe_bubble  out  1  freeze decoder this cycle

Behaviour:
- Reset values: state IDLE; busy, done, spmv_init, len_ready = 0; pipe_bubble = 1; all row_len = 0; all slots empty; counters 0.
- Per channel: slot register row_len[i], full flag, pad flag.
- Counters: fetched (real lengths accepted) and consumed (real slots popped), both DIM_W.
- Refill rule, evaluated every LOAD/RUN cycle: the lowest-indexed empty slot is target.
  - If fetched < num_rows: len_ready = 1. On len_valid & len_ready, slot <= len_data, full = 1, pad = 0, fetched++.
  - Else: slot <= 0, full = 1, pad = 1, with no handshake and len_ready = 0.
  - At most one refill per cycle.
  - No empty slot -> len_ready = 0.
- pipe_bubble = (state != RUN) | ext_stall | any slot empty. This is combinational from registered state and ext_stall.
- Consume: in RUN with pipe_bubble = 0, each i with row_len_pop[i] clears full[i].
  - consumed += popcount of popped non-pad slots.
  - Popped pad slots are refilled as pad and are not counted.
- Because pops occur only when all slots are full, the slots emptied in one cycle are refilled low-to-high before the next pop. This makes length order match decoder row-index order.
- FSM:
  - IDLE: start with num_rows = 0 -> DONE. start with num_rows != 0 -> LOAD; latch num_rows; clear counters, slots, and flags.
  - LOAD: spmv_init = 1 on the first LOAD cycle only. Fill slots; when all NUM_CH slots are full -> RUN. Minimum NUM_CH cycles.
  - RUN: refill and consume. When consumed == num_rows (after update) -> DONE. Remaining pad slots are discarded.
  - DONE: done = 1 for one cycle -> IDLE.
- Simultaneous events: a slot popped in a cycle is never refilled in that same cycle. Refill targets only slots empty at the start of the cycle.
- Stream values arriving after fetched == num_rows are not accepted (len_ready = 0).
- rst_n assertion mid-pass returns immediately to reset values. No spmv_init is issued, and a partial stream handshake is dropped.
- start in non-IDLE states is ignored.
- Counter wrap is not possible: num_rows is bounded by DIM_W.

Optional Feature:
CISR_SCHED_PERF_EN
- Defined: adds output perf_bubble_cycles [31:0] counting RUN cycles with pipe_bubble = 1. Cleared on accepted start, saturates at all-ones, holds after DONE.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- NUM_CH = 4, num_rows = 4, stream 3,1,2,5 always valid -> spmv_init at cycle 1 after start; RUN entered after 4 LOAD cycles with row_len = {5,2,1,3} (ch3..ch0), pipe_bubble = 0; done after all 4 popped.
- NUM_CH = 4, num_rows = 2, stream 7,9 -> slots ch0 = 7, ch1 = 9, ch2/ch3 pad = 0; pad pops not counted; done when both real slots popped.
- RUN, pops on ch1 and ch3 in the same cycle, next stream 4,6 -> ch1 = 4 then ch3 = 6; pipe_bubble = 1 for exactly 2 cycles.
- len_valid low for 5 cycles while a slot is empty -> pipe_bubble held 1, no slot changes, consumed unchanged.
- num_rows = 0 start -> done one cycle after DONE entry, spmv_init never asserted, len_ready stays 0.
- rst_n pulsed low in RUN -> all outputs at reset values asynchronously; new start runs a full pass correctly.
